// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_NINE = 4'h9;

    // Largest value representable in the given number of decimal digits.
    function automatic longint unsigned max_val(input int unsigned digits);
        longint unsigned p;
        p = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Single BCD digit correction applied before each double-dabble shift.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] d_i,
    output logic [DIGIT_W-1:0] d_o
);

    always_comb begin
        d_o = (d_i >= DIGIT_W'(5)) ? d_i + DIGIT_W'(3) : d_i;
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// The result register holds the last value so downstream displays stay stable.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 14,
    parameter int unsigned DIGITS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [BIN_W-1:0]           bin,
    output logic                       busy,
    output logic                       done,
    output logic [DIGIT_W*DIGITS-1:0]  bcd,
    output logic                       overflow
);

    localparam int unsigned     CNT_W   = $clog2(BIN_W + 1);
    localparam int unsigned     SCR_W   = DIGIT_W * DIGITS;
    localparam longint unsigned MAX_BIN = max_val(DIGITS);

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [SCR_W-1:0]   scratch_q, scratch_d;
    logic [SCR_W-1:0]   adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [SCR_W-1:0]   bcd_q, bcd_d;
    logic               overflow_q, overflow_d;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_add3 u_add3 (
            .d_i (scratch_q[g*DIGIT_W +: DIGIT_W]),
            .d_o (adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // busy drops on the last shift edge so the result-publishing edge can
    // also accept the next start, giving one conversion every BIN_W+1 clocks.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;

        if (state_q == SHIFT) begin
            if (cnt_q != '0) begin
                scratch_d = {adj[SCR_W-2:0], shift_q[BIN_W-1]};
                shift_d   = {shift_q[BIN_W-2:0], 1'b0};
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    busy_d = 1'b0;
                end
            end else begin
                bcd_d      = ovf_q ? {DIGITS{BCD_NINE}} : scratch_q;
                overflow_d = ovf_q;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
        end

        if (start && !busy_q) begin
            shift_d   = bin;
            scratch_d = '0;
            cnt_d     = CNT_W'(BIN_W);
            ovf_d     = (64'(bin) > MAX_BIN);
            busy_d    = 1'b1;
            state_d   = SHIFT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = overflow_q;

endmodule
